// File: rtl/ysyx_22051086_rf_pkg.sv
// Shared constants and types for the multi-port GPR file and its scoreboard.
package ysyx_22051086_rf_pkg;
    localparam int DEF_XLEN = 64;
    localparam int DEF_NREG = 32;
    localparam int DEF_TAGW = 4;
    localparam int DEF_AW   = $clog2(DEF_NREG);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] reg_data_t;
    typedef logic [DEF_TAGW-1:0] rob_tag_t;
endpackage

// File: rtl/ysyx_22051086_regfile_mp_if.sv
// Bus between the core (master) and the GPR file (slave): reads, allocation, writeback, flush.
interface ysyx_22051086_regfile_mp_if
    import ysyx_22051086_rf_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int TAGW = DEF_TAGW
) ();
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                alloc_valid;
    logic [AW-1:0]       alloc_addr;
    logic [TAGW-1:0]     alloc_tag;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NWR*TAGW-1:0] wtag;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output raddr, alloc_valid, alloc_addr, alloc_tag, wen, waddr, wdata, wtag, flush,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  raddr, alloc_valid, alloc_addr, alloc_tag, wen, waddr, wdata, wtag, flush,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/ysyx_22051086_rf_scoreboard.sv
// Busy/tag scoreboard: allocate beats flush and release; a release needs the producer tag to match.
// With REGFILE_BYPASS_EN, a same-cycle matching writeback clears the read-port busy indication.
module ysyx_22051086_rf_scoreboard #(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int TAGW = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_valid,
    input  logic [AW-1:0]       alloc_addr,
    input  logic [TAGW-1:0]     alloc_tag,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*TAGW-1:0] wtag,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD-1:0]      rd_busy,
    output logic [NREG-1:0]     busy_vec
);
    logic [NREG-1:0] busy_r;
    logic [TAGW-1:0] tag_r [NREG];
    logic [NREG-1:0] busy_s;
    logic [TAGW-1:0] tag_s [NREG];
    logic [NREG-1:0] rel_s;
    logic [NRD-1:0]  rd_busy_s;
`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0]  fwd_rel_s;
`endif

    // Release request per register: any writeback whose tag matches the stored producer.
    always_comb begin
        rel_s = {NREG{1'b0}};
        for (int a = 1; a < NREG; a++) begin
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && (waddr[p*AW +: AW] == AW'(a)) && (wtag[p*TAGW +: TAGW] == tag_r[a])) begin
                    rel_s[a] = 1'b1;
                end else begin
                    rel_s[a] = rel_s[a];
                end
            end
        end
    end

    // Next busy/tag state: allocation first, then flush or release, otherwise hold.
    always_comb begin
        busy_s = busy_r;
        tag_s  = tag_r;
        for (int a = 1; a < NREG; a++) begin
            if (alloc_valid && (alloc_addr == AW'(a))) begin
                busy_s[a] = 1'b1;
                tag_s[a]  = alloc_tag;
            end else if (flush || rel_s[a]) begin
                busy_s[a] = 1'b0;
            end else begin
                busy_s[a] = busy_r[a];
            end
        end
        busy_s[0] = 1'b0;
        tag_s[0]  = {TAGW{1'b0}};
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
            for (int a = 0; a < NREG; a++) begin
                tag_r[a] <= {TAGW{1'b0}};
            end
        end else begin
            busy_r <= busy_s;
            tag_r  <= tag_s;
        end
    end

    // Per-read-port busy lookup, optionally cleared by a same-cycle releasing writeback.
    always_comb begin
        rd_busy_s = {NRD{1'b0}};
`ifdef REGFILE_BYPASS_EN
        fwd_rel_s = {NRD{1'b0}};
`endif
        for (int i = 0; i < NRD; i++) begin
            rd_busy_s[i] = busy_r[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // The highest-index matching port decides, mirroring the data bypass.
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && (waddr[p*AW +: AW] == raddr[i*AW +: AW])) begin
                    fwd_rel_s[i] = (wtag[p*TAGW +: TAGW] == tag_r[raddr[i*AW +: AW]]);
                end else begin
                    fwd_rel_s[i] = fwd_rel_s[i];
                end
            end
            if (fwd_rel_s[i] && !(alloc_valid && (alloc_addr == raddr[i*AW +: AW]))) begin
                rd_busy_s[i] = 1'b0;
            end else begin
                rd_busy_s[i] = busy_r[raddr[i*AW +: AW]];
            end
`endif
        end
    end

    assign rd_busy  = rd_busy_s;
    assign busy_vec = busy_r;
endmodule

// File: rtl/ysyx_22051086_regfile_mp.sv
// Multi-port GPR file with producer-tagged busy scoreboard; x0 reads zero and is never busy.
// Optional same-cycle write-through bypass under REGFILE_BYPASS_EN.
module ysyx_22051086_regfile_mp
    import ysyx_22051086_rf_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int TAGW = DEF_TAGW
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_22051086_regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]     rf [NREG];
    logic [NRD*XLEN-1:0] rdata_s;
    logic [NRD-1:0]      rd_busy_s;
    logic [NREG-1:0]     busy_vec_s;

    // Data array; later ports are written last so the highest index wins on conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NREG; a++) begin
                rf[a] <= {XLEN{1'b0}};
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.wen[p] && (bus.waddr[p*AW +: AW] != {AW{1'b0}})) begin
                    rf[bus.waddr[p*AW +: AW]] <= bus.wdata[p*XLEN +: XLEN];
                end else begin
                    rf[0] <= {XLEN{1'b0}};
                end
            end
        end
    end

    // Combinational read ports with optional writeback forwarding.
    always_comb begin
        rdata_s = {(NRD*XLEN){1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rdata_s[i*XLEN +: XLEN] = rf[bus.raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed while in reset so outputs stay zero.
            for (int p = 0; p < NWR; p++) begin
                rdata_s[i*XLEN +: XLEN] =
                    (rst_n && bus.wen[p]
                     && (bus.waddr[p*AW +: AW] == bus.raddr[i*AW +: AW])
                     && (bus.raddr[i*AW +: AW] != {AW{1'b0}}))
                    ? bus.wdata[p*XLEN +: XLEN] : rdata_s[i*XLEN +: XLEN];
            end
`endif
        end
    end

    ysyx_22051086_rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .TAGW (TAGW),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (bus.alloc_valid),
        .alloc_addr  (bus.alloc_addr),
        .alloc_tag   (bus.alloc_tag),
        .wen         (bus.wen),
        .waddr       (bus.waddr),
        .wtag        (bus.wtag),
        .flush       (bus.flush),
        .raddr       (bus.raddr),
        .rd_busy     (rd_busy_s),
        .busy_vec    (busy_vec_s)
    );

    assign bus.rdata    = rdata_s;
    assign bus.rbusy    = rd_busy_s;
    assign bus.busy_vec = busy_vec_s;
endmodule
